// File: rtl/evm_pkg.sv
// -----------------------------------------------------------------------------
// evm_pkg
// Shared definitions for the EVM ballot controller and its helpers:
//   - state_e      : ballot/session controller states
//   - winner_t     : winner encoding (WIN_NONE = no votes, WIN_C1..WIN_C3)
//   - CNT_W_DEFAULT: default width of the datapath vote counts
//   - is_single_btn: true when exactly one candidate button is pressed
// -----------------------------------------------------------------------------
package evm_pkg;

    localparam int CNT_W_DEFAULT = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_DEBOUNCE,
        ST_COMMIT,
        ST_RELEASE,
        ST_CLOSED,
        ST_TALLY,
        ST_DONE
    } state_e;

    typedef logic [1:0] winner_t;

    localparam winner_t WIN_NONE = 2'd0;
    localparam winner_t WIN_C1   = 2'd1;
    localparam winner_t WIN_C2   = 2'd2;
    localparam winner_t WIN_C3   = 2'd3;

    // Buttons are packed {cand3, cand2, cand1}; a valid choice is one-hot.
    function automatic logic is_single_btn(input logic [2:0] btn);
        return (btn == 3'b001) || (btn == 3'b010) || (btn == 3'b100);
    endfunction

endpackage

// File: rtl/evm_max3.sv
// -----------------------------------------------------------------------------
// evm_max3
// Combinational 3-way maximum / tie detector over the candidate vote counts.
// Ports:
//   a_i, b_i, c_i : counts for candidates 1, 2, 3 (unsigned)
//   winner_o      : index of the maximum count, lowest index on a tie,
//                   WIN_NONE when every count is zero
//   tie_o         : maximum shared by two or more candidates (0 if all zero)
// -----------------------------------------------------------------------------
module evm_max3 import evm_pkg::*; #(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic [CNT_W-1:0] a_i,
    input  logic [CNT_W-1:0] b_i,
    input  logic [CNT_W-1:0] c_i,
    output winner_t          winner_o,
    output logic             tie_o
);

    logic [CNT_W-1:0] max_v;
    winner_t          max_idx;
    logic [1:0]       n_top;

    // NOTE: every signal written here gets a value before any branch, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        max_v   = a_i;
        max_idx = WIN_C1;
        // Strictly-greater replaces the leader, so equal counts keep the
        // lower candidate index.
        if (b_i > max_v) begin
            max_v   = b_i;
            max_idx = WIN_C2;
        end
        if (c_i > max_v) begin
            max_v   = c_i;
            max_idx = WIN_C3;
        end

        n_top = {1'b0, (a_i == max_v)} + {1'b0, (b_i == max_v)} + {1'b0, (c_i == max_v)};

        // An all-zero poll has no winner and is not reported as a tie.
        winner_o = (max_v == '0) ? WIN_NONE : max_idx;
        tie_o    = (max_v != '0) && (n_top >= 2'd2);
    end

endmodule

// File: rtl/evm_ballot_ctrl.sv
// -----------------------------------------------------------------------------
// evm_ballot_ctrl
// Session controller for the electronic voting machine. Admits one debounced
// vote per officer authorisation, drives one-cycle increment strobes into the
// vote-count datapath, closes the poll on voting_over and then registers the
// winner computed from the datapath counts.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   ballot_en             : officer authorises one ballot (level)
//   cand1..cand3          : candidate push-buttons (synchronous to clk)
//   voting_over           : close the poll (level, takes effect next cycle)
//   rcnt1..rcnt3          : current counts from the datapath
//   inc1..inc3            : one-cycle increment strobes to the datapath
//   ready_lamp, busy_lamp : voter-facing status lamps
//   timeout               : one-cycle pulse, armed ballot cancelled unused
//   closed                : poll closed (held until reset)
//   result_valid, winner, tie : registered poll result
// -----------------------------------------------------------------------------
module evm_ballot_ctrl import evm_pkg::*; #(
    parameter int CNT_W        = CNT_W_DEFAULT,
    parameter int DEBOUNCE_CYC = 4,
    parameter int TIMEOUT_CYC  = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ballot_en,
    input  logic             cand1,
    input  logic             cand2,
    input  logic             cand3,
    input  logic             voting_over,
    input  logic [CNT_W-1:0] rcnt1,
    input  logic [CNT_W-1:0] rcnt2,
    input  logic [CNT_W-1:0] rcnt3,
    output logic             inc1,
    output logic             inc2,
    output logic             inc3,
    output logic             ready_lamp,
    output logic             busy_lamp,
    output logic             timeout,
    output logic             closed,
    output logic             result_valid,
    output logic [1:0]       winner,
    output logic             tie
);

    localparam int DEB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC + 1) : 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    // The debounce count starts at 1 on ARMED exit, so the cycle that sees it
    // at DEBOUNCE_CYC-1 with the button still held is the last one.
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYC - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    state_e           state_q,   state_d;
    logic [2:0]       choice_q,  choice_d;   // one-hot {c3,c2,c1}
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             timeout_q, timeout_d;
    winner_t          winner_q,  winner_d;
    logic             tie_q,     tie_d;

    logic [2:0] btn;
    logic       btn_single;
    logic       tmo_hit;
    winner_t    max_winner;
    logic       max_tie;

    assign btn        = {cand3, cand2, cand1};
    assign btn_single = is_single_btn(btn);
    assign tmo_hit    = (tmo_cnt_q == TMO_LAST);

    evm_max3 #(
        .CNT_W (CNT_W)
    ) u_max3 (
        .a_i      (rcnt1),
        .b_i      (rcnt2),
        .c_i      (rcnt3),
        .winner_o (max_winner),
        .tie_o    (max_tie)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            choice_q  <= '0;
            deb_cnt_q <= '0;
            tmo_cnt_q <= '0;
            timeout_q <= 1'b0;
            winner_q  <= WIN_NONE;
            tie_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            choice_q  <= choice_d;
            deb_cnt_q <= deb_cnt_d;
            tmo_cnt_q <= tmo_cnt_d;
            timeout_q <= timeout_d;
            winner_q  <= winner_d;
            tie_q     <= tie_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        choice_d  = choice_q;
        deb_cnt_d = deb_cnt_q;
        timeout_d = 1'b0;
        winner_d  = winner_q;
        tie_d     = tie_q;

        // The timeout window spans ARMED and DEBOUNCE, including bounces
        // back from DEBOUNCE to ARMED; any other state restarts it.
        if (state_q == ST_ARMED || state_q == ST_DEBOUNCE) begin
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end else begin
            tmo_cnt_d = '0;
        end

        unique case (state_q)
            ST_IDLE: begin
                choice_d = '0;
                if (voting_over) begin
                    state_d = ST_CLOSED;
                end else if (ballot_en) begin
                    state_d = ST_ARMED;
                end
            end

            ST_ARMED: begin
                if (voting_over) begin
                    state_d = ST_CLOSED;
                end else if (btn_single && DEBOUNCE_CYC == 1) begin
                    // A one-cycle debounce is already satisfied by this press.
                    choice_d = btn;
                    state_d  = ST_COMMIT;
                end else if (tmo_hit) begin
                    timeout_d = 1'b1;
                    state_d   = ST_RELEASE;
                end else if (btn_single) begin
                    choice_d  = btn;
                    deb_cnt_d = DEB_W'(1);
                    state_d   = ST_DEBOUNCE;
                end
            end

            ST_DEBOUNCE: begin
                if (voting_over) begin
                    state_d = ST_CLOSED;
                end else if (btn == choice_q && deb_cnt_q == DEB_LAST) begin
                    // A vote that completes on the last allowed cycle wins
                    // over the timeout.
                    state_d = ST_COMMIT;
                end else if (tmo_hit) begin
                    timeout_d = 1'b1;
                    state_d   = ST_RELEASE;
                end else if (btn == choice_q) begin
                    deb_cnt_d = deb_cnt_q + DEB_W'(1);
                end else begin
                    state_d = ST_ARMED;
                end
            end

            ST_COMMIT: begin
                // The strobe for this cycle is issued even when the poll closes.
                state_d = voting_over ? ST_CLOSED : ST_RELEASE;
            end

            ST_RELEASE: begin
                if (voting_over) begin
                    state_d = ST_CLOSED;
                end else if (btn == 3'b000) begin
                    state_d = ST_IDLE;
                end
            end

            // One idle cycle lets a strobe issued in COMMIT land in the counters.
            ST_CLOSED: state_d = ST_TALLY;

            ST_TALLY: begin
                winner_d = max_winner;
                tie_d    = max_tie;
                state_d  = ST_DONE;
            end

            ST_DONE: state_d = ST_DONE;

            default: state_d = ST_IDLE;
        endcase
    end

    assign inc1         = (state_q == ST_COMMIT) && choice_q[0];
    assign inc2         = (state_q == ST_COMMIT) && choice_q[1];
    assign inc3         = (state_q == ST_COMMIT) && choice_q[2];
    assign ready_lamp   = (state_q == ST_ARMED);
    assign busy_lamp    = (state_q == ST_DEBOUNCE) || (state_q == ST_COMMIT) ||
                          (state_q == ST_RELEASE);
    assign timeout      = timeout_q;
    assign closed       = (state_q == ST_CLOSED) || (state_q == ST_TALLY) ||
                          (state_q == ST_DONE);
    assign result_valid = (state_q == ST_DONE);
    assign winner       = winner_q;
    assign tie          = tie_q;

endmodule

// File: tb/tb_evm_ballot_ctrl.sv
// -----------------------------------------------------------------------------
// tb_evm_ballot_ctrl
// Self-checking bench for evm_ballot_ctrl. A small behavioural datapath holds
// the vote counts driven by the increment strobes; a reference model decides,
// from each ballot's button sequence, whether and when a vote must be cast.
// -----------------------------------------------------------------------------
module tb_evm_ballot_ctrl;

    localparam int CW  = 8;
    localparam int DEB = 4;
    localparam int TMO = 40;

    logic          clk = 1'b0;
    logic          rst;
    logic          ballot_en;
    logic          cand1, cand2, cand3;
    logic          voting_over;
    logic [CW-1:0] rcnt1, rcnt2, rcnt3;
    logic          inc1, inc2, inc3;
    logic          ready_lamp, busy_lamp, timeout, closed, result_valid, tie;
    logic [1:0]    winner;

    // Datapath stand-in
    logic          dp_clr, dp_load;
    logic [CW-1:0] ld1, ld2, ld3;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_cnt [3];

    logic [2:0] bseq [64];
    int         bn;

    always #5 clk = ~clk;

    evm_ballot_ctrl #(
        .CNT_W        (CW),
        .DEBOUNCE_CYC (DEB),
        .TIMEOUT_CYC  (TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ballot_en    (ballot_en),
        .cand1        (cand1),
        .cand2        (cand2),
        .cand3        (cand3),
        .voting_over  (voting_over),
        .rcnt1        (rcnt1),
        .rcnt2        (rcnt2),
        .rcnt3        (rcnt3),
        .inc1         (inc1),
        .inc2         (inc2),
        .inc3         (inc3),
        .ready_lamp   (ready_lamp),
        .busy_lamp    (busy_lamp),
        .timeout      (timeout),
        .closed       (closed),
        .result_valid (result_valid),
        .winner       (winner),
        .tie          (tie)
    );

    always @(posedge clk) begin
        if (dp_clr) begin
            rcnt1 <= '0; rcnt2 <= '0; rcnt3 <= '0;
        end else if (dp_load) begin
            rcnt1 <= ld1; rcnt2 <= ld2; rcnt3 <= ld3;
        end else begin
            if (inc1) rcnt1 <= rcnt1 + 1'b1;
            if (inc2) rcnt2 <= rcnt2 + 1'b1;
            if (inc3) rcnt3 <= rcnt3 + 1'b1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_btn(input logic [2:0] b);
        {cand3, cand2, cand1} = b;
    endtask

    function automatic logic [2:0] get_btn(input int i);
        return (i < bn) ? bseq[i] : 3'b000;
    endfunction

    function automatic bit is_single(input logic [2:0] b);
        return (b == 3'b001) || (b == 3'b010) || (b == 3'b100);
    endfunction

    task automatic do_reset();
        rst = 1'b1; ballot_en = 1'b0; voting_over = 1'b0; set_btn(3'b000);
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic clear_counts();
        dp_clr = 1'b1;
        step();
        dp_clr = 1'b0;
        for (int c = 0; c < 3; c++) exp_cnt[c] = 0;
    endtask

    // Reference ballot: scanning from the arm cycle, a press that stays the
    // same single button for DEB cycles casts a vote DEB cycles after it
    // started; a change restarts the search on the following cycle. The vote
    // counts only if it lands no later than TMO cycles after arming,
    // otherwise the ballot times out at TMO.
    task automatic model_ballot(output int k, output int cand);
        int p, q;
        logic [2:0] b;
        k = 0; cand = -1; p = 0;
        while (p < TMO) begin
            b = get_btn(p);
            if (is_single(b)) begin
                q = p + 1;
                while (q < p + DEB && get_btn(q) == b) q++;
                if (q == p + DEB) begin
                    if (p + DEB <= TMO) begin
                        k = p + DEB;
                        cand = (b == 3'b001) ? 0 : (b == 3'b010) ? 1 : 2;
                    end
                    break;
                end
                p = q + 1;
            end else begin
                p++;
            end
        end
    endtask

    task automatic run_ballot(input string name);
        int k, cand, strobe_idx, tmo_n, tmo_idx, multi;
        int got [3];
        logic busy_after;
        model_ballot(k, cand);
        strobe_idx = 0; tmo_n = 0; tmo_idx = 0; multi = 0; busy_after = 1'b0;
        for (int c = 0; c < 3; c++) got[c] = 0;

        ballot_en = 1'b1; set_btn(3'b000);
        step();
        ballot_en = 1'b0;
        n_cmp++;
        if (ready_lamp !== 1'b1) begin
            n_bad++; $display("FAIL %s_ready: got %b expected 1", name, ready_lamp);
        end

        for (int j = 0; j < TMO + 8; j++) begin
            set_btn(get_btn(j));
            step();
            if (inc1) got[0]++;
            if (inc2) got[1]++;
            if (inc3) got[2]++;
            if ({inc1, inc2, inc3} != 3'b000) strobe_idx = j + 1;
            if ($countones({inc1, inc2, inc3}) > 1) multi++;
            if (timeout) begin tmo_n++; tmo_idx = j + 1; end
            if (k > 0 && j + 1 == k + 1) busy_after = busy_lamp;
        end
        set_btn(3'b000);

        for (int c = 0; c < 3; c++) begin
            n_cmp++;
            if (got[c] !== ((cand == c) ? 1 : 0)) begin
                n_bad++;
                $display("FAIL %s_inc%0d: got %0d strobes expected %0d", name, c + 1, got[c], (cand == c) ? 1 : 0);
            end
        end
        n_cmp++;
        if (multi !== 0) begin
            n_bad++; $display("FAIL %s_simul: got %0d simultaneous strobes expected 0", name, multi);
        end
        n_cmp++;
        if (tmo_n !== ((k == 0) ? 1 : 0)) begin
            n_bad++; $display("FAIL %s_tmo_cnt: got %0d expected %0d", name, tmo_n, (k == 0) ? 1 : 0);
        end
        if (k > 0) begin
            n_cmp++;
            if (strobe_idx !== k) begin
                n_bad++; $display("FAIL %s_latency: got cycle %0d expected %0d", name, strobe_idx, k);
            end
            n_cmp++;
            if (busy_after !== 1'b1) begin
                n_bad++; $display("FAIL %s_release_busy: got %b expected 1", name, busy_after);
            end
        end else begin
            n_cmp++;
            if (tmo_idx !== TMO) begin
                n_bad++; $display("FAIL %s_tmo_cycle: got %0d expected %0d", name, tmo_idx, TMO);
            end
        end
        n_cmp++;
        if ({ready_lamp, busy_lamp} !== 2'b00) begin
            n_bad++; $display("FAIL %s_idle: got ready/busy %b expected 00", name, {ready_lamp, busy_lamp});
        end
        if (cand >= 0) exp_cnt[cand]++;
    endtask

    task automatic close_and_check(input string name);
        int m, ew, ntop;
        bit et;
        m = 0;
        for (int c = 0; c < 3; c++) if (exp_cnt[c] > m) m = exp_cnt[c];
        ew = 0; ntop = 0;
        for (int c = 2; c >= 0; c--) if (m > 0 && exp_cnt[c] == m) begin ew = c + 1; ntop++; end
        et = (ntop >= 2);

        voting_over = 1'b1;
        step();
        voting_over = 1'b0;
        n_cmp++;
        if ({closed, result_valid} !== 2'b10) begin
            n_bad++; $display("FAIL %s_closed: got closed/valid %b expected 10", name, {closed, result_valid});
        end
        step();
        n_cmp++;
        if (result_valid !== 1'b0) begin
            n_bad++; $display("FAIL %s_early_valid: got %b expected 0", name, result_valid);
        end
        step();
        n_cmp++;
        if ({closed, result_valid} !== 2'b11) begin
            n_bad++; $display("FAIL %s_valid: got closed/valid %b expected 11", name, {closed, result_valid});
        end
        n_cmp++;
        if (winner !== 2'(ew) || tie !== et) begin
            n_bad++; $display("FAIL %s_result: got winner %0d tie %b expected winner %0d tie %b", name, winner, tie, ew, et);
        end
        n_cmp++;
        if (rcnt1 !== CW'(exp_cnt[0]) || rcnt2 !== CW'(exp_cnt[1]) || rcnt3 !== CW'(exp_cnt[2])) begin
            n_bad++;
            $display("FAIL %s_counts: got %0d/%0d/%0d expected %0d/%0d/%0d", name, rcnt1, rcnt2, rcnt3, exp_cnt[0], exp_cnt[1], exp_cnt[2]);
        end
    endtask

    task automatic test_reset();
        do_reset();
        clear_counts();
        rst = 1'b1;
        step();
        n_cmp++;
        if ({inc1, inc2, inc3, ready_lamp, busy_lamp, timeout, closed, result_valid, winner, tie} !== 11'd0) begin
            n_bad++; $display("FAIL reset_outputs: got %b expected all 0",
                {inc1, inc2, inc3, ready_lamp, busy_lamp, timeout, closed, result_valid, winner, tie});
        end
        rst = 1'b0;
    endtask

    task automatic test_single_vote();
        bn = 7;
        for (int i = 0; i < bn; i++) bseq[i] = 3'b010;
        run_ballot("single_c2");
    endtask

    task automatic test_bounce();
        logic [2:0] pat [12] = '{3'b001, 3'b001, 3'b000, 3'b000, 3'b101, 3'b101,
                                 3'b101, 3'b101, 3'b001, 3'b001, 3'b001, 3'b001};
        bn = 12;
        for (int i = 0; i < bn; i++) bseq[i] = pat[i];
        run_ballot("bounce_c1");
        bn = 10;
        for (int i = 0; i < bn; i++) bseq[i] = 3'b101;
        run_ballot("overlap");
    endtask

    task automatic test_timeout();
        bn = 0;
        run_ballot("timeout");
    endtask

    task automatic test_hold_ballot_en();
        int n3, nother;
        n3 = 0; nother = 0;
        ballot_en = 1'b1; set_btn(3'b000);
        step();
        set_btn(3'b100);
        for (int j = 0; j < 20; j++) begin
            step();
            if (inc3) n3++;
            if (inc1 || inc2) nother++;
        end
        set_btn(3'b000); ballot_en = 1'b0;
        step();
        step();
        n_cmp++;
        if (n3 !== 1 || nother !== 0) begin
            n_bad++; $display("FAIL hold_en_strobes: got inc3 %0d other %0d expected 1 and 0", n3, nother);
        end
        n_cmp++;
        if ({ready_lamp, busy_lamp} !== 2'b00) begin
            n_bad++; $display("FAIL hold_en_idle: got ready/busy %b expected 00", {ready_lamp, busy_lamp});
        end
        exp_cnt[2]++;
    endtask

    task automatic test_results();
        logic [2:0] votes [4] = '{3'b001, 3'b010, 3'b001, 3'b100};
        do_reset(); clear_counts();
        bn = 4;
        for (int v = 0; v < 4; v++) begin
            for (int i = 0; i < bn; i++) bseq[i] = votes[v];
            run_ballot("tally_vote");
        end
        close_and_check("result_2_1_1");

        do_reset(); clear_counts();
        for (int v = 0; v < 4; v++) begin
            for (int i = 0; i < bn; i++) bseq[i] = (v % 2 == 0) ? 3'b001 : 3'b010;
            run_ballot("tie_vote");
        end
        close_and_check("result_tie");

        do_reset(); clear_counts();
        close_and_check("result_zero");
    endtask

    task automatic test_close_in_debounce();
        int nstrobe;
        nstrobe = 0;
        do_reset(); clear_counts();
        ballot_en = 1'b1; step(); ballot_en = 1'b0;
        set_btn(3'b001);
        step(); step();
        voting_over = 1'b1;
        step();
        voting_over = 1'b0;
        if ({inc1, inc2, inc3} != 3'b000) nstrobe++;
        n_cmp++;
        if (closed !== 1'b1) begin
            n_bad++; $display("FAIL deb_close: got closed %b expected 1", closed);
        end
        for (int j = 0; j < 10; j++) begin
            ballot_en = 1'b1;
            set_btn(3'($urandom_range(1, 7)));
            step();
            if ({inc1, inc2, inc3} != 3'b000) nstrobe++;
        end
        ballot_en = 1'b0; set_btn(3'b000);
        n_cmp++;
        if (nstrobe !== 0 || closed !== 1'b1) begin
            n_bad++; $display("FAIL after_close: got strobes %0d closed %b expected 0 and 1", nstrobe, closed);
        end
        n_cmp++;
        if ({result_valid, winner, tie} !== 4'b1000) begin
            n_bad++; $display("FAIL deb_close_result: got valid/winner/tie %b expected 1000", {result_valid, winner, tie});
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++;
        if ({inc1, inc2, inc3, ready_lamp, busy_lamp, timeout, closed, result_valid, winner, tie} !== 11'd0) begin
            n_bad++; $display("FAIL rst_in_done: got %b expected all 0",
                {inc1, inc2, inc3, ready_lamp, busy_lamp, timeout, closed, result_valid, winner, tie});
        end
    endtask

    task automatic test_close_in_commit();
        do_reset(); clear_counts();
        ballot_en = 1'b1; step(); ballot_en = 1'b0;
        set_btn(3'b100);
        for (int j = 0; j < DEB; j++) step();
        n_cmp++;
        if ({inc1, inc2, inc3} !== 3'b001) begin
            n_bad++; $display("FAIL commit_strobe: got inc %b expected 001", {inc1, inc2, inc3});
        end
        exp_cnt[2]++;
        set_btn(3'b000);
        close_and_check("close_in_commit");
    endtask

    task automatic test_rst_abort();
        int nstrobe;
        nstrobe = 0;
        do_reset(); clear_counts();
        ballot_en = 1'b1; step(); ballot_en = 1'b0;
        set_btn(3'b010);
        step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int j = 0; j < 6; j++) begin
            step();
            if ({inc1, inc2, inc3} != 3'b000) nstrobe++;
        end
        set_btn(3'b000);
        n_cmp++;
        if (nstrobe !== 0 || {ready_lamp, busy_lamp} !== 2'b00) begin
            n_bad++; $display("FAIL rst_abort: got strobes %0d ready/busy %b expected 0 and 00", nstrobe, {ready_lamp, busy_lamp});
        end
    endtask

    task automatic test_random_ballots();
        logic [2:0] choices [8] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b011, 3'b101, 3'b110, 3'b111};
        logic [2:0] prev;
        do_reset(); clear_counts();
        for (int b = 0; b < 25; b++) begin
            bn = $urandom_range(0, 20);
            prev = 3'b000;
            for (int i = 0; i < bn; i++) begin
                if ($urandom_range(0, 9) >= 6) prev = choices[$urandom_range(0, 7)];
                bseq[i] = prev;
            end
            run_ballot("random");
        end
        close_and_check("random_close");
    endtask

    task automatic test_tally_random();
        for (int it = 0; it < 20; it++) begin
            do_reset();
            if (it % 2 == 0) begin
                ld1 = CW'($urandom_range(0, 2)); ld2 = CW'($urandom_range(0, 2)); ld3 = CW'($urandom_range(0, 2));
            end else begin
                ld1 = CW'($urandom); ld2 = CW'($urandom); ld3 = CW'($urandom);
            end
            dp_load = 1'b1;
            step();
            dp_load = 1'b0;
            exp_cnt[0] = int'(ld1); exp_cnt[1] = int'(ld2); exp_cnt[2] = int'(ld3);
            close_and_check("tally_random");
        end
    endtask

    initial begin
        rst = 1'b1; ballot_en = 1'b0; voting_over = 1'b0; set_btn(3'b000);
        dp_clr = 1'b1; dp_load = 1'b0; ld1 = '0; ld2 = '0; ld3 = '0;
        for (int c = 0; c < 3; c++) exp_cnt[c] = 0;
        bn = 0;

        test_reset();
        test_single_vote();
        test_bounce();
        test_timeout();
        test_hold_ballot_en();
        test_results();
        test_close_in_debounce();
        test_close_in_commit();
        test_rst_abort();
        test_random_ballots();
        test_tally_random();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/evm_ballot_ctrl.md
# evm_ballot_ctrl

Session controller for the electronic voting machine. It sits between the presiding-officer console, the candidate push-buttons and the `evm` vote-count datapath. It admits exactly one debounced vote per officer authorisation and drives one-cycle increment strobes into the counters. It closes the poll on `voting_over` and then computes the winner from the datapath counts.

## Interface
Parameters:
- `CNT_W`, 32, width of datapath vote counts
- `DEBOUNCE_CYC`, 4, consecutive cycles a single button must be held before the vote is accepted (≥1)
- `TIMEOUT_CYC`, 1000, cycles an authorised ballot may stay unused before it is cancelled (> `DEBOUNCE_CYC`)

Ports:
- `clk` in 1: single clock; all logic on rising edge
- `rst` in 1: reset, synchronous and active-high
- `ballot_en` in 1: officer authorise, level-sampled
- `cand1`, `cand2`, `cand3` in 1 each: candidate buttons, synchronous to `clk`
- `voting_over` in 1: close poll, level-sampled, sticky once seen
- `rcnt1`, `rcnt2`, `rcnt3` in `CNT_W` each: current counts from datapath
- `inc1`, `inc2`, `inc3` out 1 each: one-cycle increment strobes to datapath
- `ready_lamp` out 1: ballot armed, voter may press
- `busy_lamp` out 1: vote in progress or awaiting button release
- `timeout` out 1: one-cycle pulse, armed ballot cancelled unused
- `closed` out 1: poll closed
- `result_valid` out 1: `winner`/`tie` valid
- `winner` out 2: 0 = no votes, 1..3 = candidate index
- `tie` out 1: top count shared by ≥2 candidates

## Operation
States: IDLE, ARMED, DEBOUNCE, COMMIT, RELEASE, CLOSED, TALLY, DONE.
- IDLE → ARMED when `ballot_en`=1 and `voting_over`=0.
- ARMED: `ready_lamp`=1.
  - Exactly one button high → DEBOUNCE; that choice is latched and the debounce count is set to 1.
  - Zero buttons high, or two or more high → stay in ARMED.
- DEBOUNCE: `busy_lamp`=1.
  - Same single button still high → count increments.
  - Count reaching `DEBOUNCE_CYC` → COMMIT.
  - Any change (release, different button, extra button) → ARMED.
- COMMIT: exactly one `incN`=1 for the latched choice, then → RELEASE.
- RELEASE: `busy_lamp`=1; → IDLE when all buttons are low. Holding a button therefore never casts a second vote, even if `ballot_en` is still high.
- Timeout: a counter starts on ARMED entry and runs through ARMED and DEBOUNCE. On reaching `TIMEOUT_CYC` with no COMMIT: `timeout` pulses for 1 cycle, no strobe is issued, state → RELEASE.
- `voting_over`=1, effective the next cycle:
  - IDLE, ARMED, DEBOUNCE or RELEASE → CLOSED; a partially debounced vote is discarded.
  - COMMIT → the strobe is still issued, then → CLOSED.
  - `voting_over` has priority over `ballot_en` and over timeout in the same cycle.
- CLOSED: `closed`=1 and stays 1 until `rst`. All `incN` are held 0 and buttons and `ballot_en` are ignored. → TALLY after 1 cycle, which lets the final increment land in the datapath.
- TALLY: unsigned compare of `rcnt1..3`; the result is registered. → DONE.
- DONE: `result_valid`=1; `winner` = index of maximum count, lowest index on a tie. `tie`=1 if the maximum is shared by ≥2 candidates. All counts zero → `winner`=0, `tie`=0. Stays in DONE until `rst`.

## Timing
- Reset: state IDLE; all outputs 0; counters and latched choice cleared.
- `rst` mid-operation aborts any ballot with no strobe; it takes priority over every other input.
- Button-to-strobe latency: a button stably high from cycle t (with state ARMED at t) gives `incN`=1 at cycle t+`DEBOUNCE_CYC`.
- `ballot_en` high at cycle t in IDLE → `ready_lamp`=1 at t+1.
- At most one strobe per authorisation. Strobes are never simultaneous.
- `voting_over` at cycle t in IDLE → `closed`=1 at t+1 → `result_valid`=1 at t+3.
- `rcnt*` are assumed stable from CLOSED onward; no wrap handling is needed in this block.

## Structure
- Shared package `evm_pkg`: state enum, `CNT_W` default, `winner` encoding constants (`WIN_NONE`=0, `WIN_C1..3`).
- One sub-module: `evm_max3`, a combinational 3-way max/tie comparator used in TALLY.
- Instantiated beside `evm`; the `incN` strobes feed the `evm` count-enable path.

## Test plan
- Reset, `ballot_en` pulse, hold `cand2` for 4 cycles → single `inc2` pulse, RELEASE until `cand2` drops, then IDLE.
- Armed, `cand1` held 2 cycles then released, later held 4 cycles → exactly one `inc1`; a `cand1`+`cand3` overlap causes no strobe.
- `ballot_en` held high with `cand3` held for 20 cycles → exactly one `inc3`.
- Armed, no press for `TIMEOUT_CYC` cycles → `timeout` pulses once, no `incN`, IDLE after buttons are low.
- Votes c1,c2,c1,c3, then `voting_over` → `closed`=1, `result_valid`=1 after 3 cycles, `winner`=1, `tie`=0. With counts 2,2,0 → `winner`=1, `tie`=1. All zero → `winner`=0.
- `voting_over` during DEBOUNCE → no strobe. Button presses after `closed` → no strobe. `rst` in DONE → all outputs 0.
